// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one request per RUN cycle, returns memory data the next cycle,
// holds it under stall, squashes on redirect, stops on the halt encoding and keeps performance counters.
module instr_fetch #(
  parameter int                     instr_width = 9,
  parameter int                     count_width = 16,
  parameter logic [instr_width-1:0] halt_instr  = 9'h1FF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [instr_width-1:0] pc_in,
  input  logic                   redirect,
  input  logic                   stall,
  output logic [instr_width-1:0] mem_addr,
  input  logic [instr_width-1:0] mem_rdata,
  output logic [instr_width-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [count_width-1:0] instr_count,
  output logic [count_width-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                   pend_p1;
  logic                   hold_vld_p1;
  logic [instr_width-1:0] hold_data_p1;

  logic run;
  logic accept;
  logic halt_hit;
  logic issue;
  logic capture;

  function automatic logic [count_width-1:0] sat_inc(input logic [count_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Fetch stage p0: request decision and output selection for the current cycle
  always_comb begin
    run         = (state == RUN);
    mem_addr    = pc_in;
    busy        = run;
    instr_valid = run && (hold_vld_p1 || pend_p1);
    instr_out   = '0;
    if (instr_valid) begin
      instr_out = hold_vld_p1 ? hold_data_p1 : mem_rdata;
    end
    accept   = instr_valid && !stall;
    halt_hit = accept && (instr_out == halt_instr);
    done     = halt_hit && !start;
    // A stalled valid instruction blocks new requests; the halt ends fetching outright.
    issue    = run && !halt_hit && (!stall || !instr_valid);
    capture  = run && instr_valid && stall;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (halt_hit) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch stage p1: in-flight request and hold register control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_p1     <= 1'b0;
      hold_vld_p1 <= 1'b0;
    end else if (start) begin
      pend_p1     <= 1'b0;
      hold_vld_p1 <= 1'b0;
    end else begin
      pend_p1     <= issue && !redirect;
      hold_vld_p1 <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      hold_data_p1 <= instr_out;
    end
  end

  // Counter stage p1: saturating performance counters, frozen outside RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else if (start) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else if (run) begin
      cycle_count <= sat_inc(cycle_count);
      if (accept) begin
        instr_count <= sat_inc(instr_count);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_instr_fetch;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic       clk = 1'b0;
  logic       reset, start, redirect, stall;
  logic [8:0] pc_in, mem_addr, mem_rdata, instr_out;
  logic       instr_valid, busy, done;
  logic [15:0] instr_count, cycle_count;
  logic [8:0] mem_addr4, instr_out4;
  logic       instr_valid4, busy4, done4;
  logic [3:0] instr_count4, cycle_count4;

  logic [8:0] mem [512];

  int n_chk = 0, n_pass = 0;
  int m_state, m_ic, m_cc, obs_dones;
  bit m_infl, m_held;
  logic [8:0] m_data, m_hval;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .redirect(redirect), .stall(stall),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
    .busy(busy), .done(done), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  instr_fetch #(.count_width(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .redirect(redirect), .stall(stall),
    .mem_addr(mem_addr4), .mem_rdata(mem_rdata), .instr_out(instr_out4), .instr_valid(instr_valid4),
    .busy(busy4), .done(done4), .instr_count(instr_count4), .cycle_count(cycle_count4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned sat(input int unsigned v, input int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_state = M_IDLE; m_ic = 0; m_cc = 0; m_infl = 0; m_held = 0;
  endtask

  task automatic tick(input bit s, input logic [8:0] pc, input bit r, input bit st);
    bit ev, eh, ed;
    logic [8:0] eo;
    @(posedge clk);
    #1;
    start = s; pc_in = pc; redirect = r; stall = st;
    #2;
    ev = (m_state == M_RUN) && (m_held || m_infl);
    eo = !ev ? 9'h000 : (m_held ? m_hval : m_data);
    eh = ev && !st && (eo == HALT);
    ed = eh && !s;
    chk("instr_valid", instr_valid, ev);
    chk("instr_out", instr_out, eo);
    chk("busy", busy, m_state == M_RUN);
    chk("done", done, ed);
    chk("instr_count", instr_count, sat(m_ic, 16));
    chk("cycle_count", cycle_count, sat(m_cc, 16));
    chk("mem_addr", mem_addr, pc);
    chk("instr_valid_w4", instr_valid4, ev);
    chk("mem_addr_w4", mem_addr4, pc);
    chk("instr_count_w4", instr_count4, sat(m_ic, 4));
    chk("cycle_count_w4", cycle_count4, sat(m_cc, 4));
    if (done) obs_dones++;
    if (s) begin
      m_state = M_RUN; m_ic = 0; m_cc = 0; m_infl = 0; m_held = 0;
    end else if (m_state == M_RUN) begin
      m_cc++;
      if (ev && !st) m_ic++;
      if (eh) begin
        m_state = M_DONE; m_infl = 0; m_held = 0;
      end else begin
        m_held = ev && st;
        m_hval = eo;
        m_infl = (!st || !ev) && !r;
        m_data = mem[pc];
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; redirect = 1'b0; stall = 1'b0; pc_in = '0;
    obs_dones = 0;
    for (int a = 0; a < 512; a++) mem[a] = 9'(a + 16);
    mem[9'h1EF] = 9'h000;
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_icount", instr_count, 0);
    chk("rst_ccount", cycle_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Sequential fetch, redirect squash, stall hold
    tick(1, 9'd0, 0, 0);
    tick(0, 9'd0, 0, 0);  chk("seq_busy", busy, 1);
    tick(0, 9'd1, 0, 0);  chk("seq_out0", instr_out, 9'h010); chk("seq_vld0", instr_valid, 1);
    tick(0, 9'd2, 0, 0);  chk("seq_out1", instr_out, 9'h011);
    tick(0, 9'd3, 0, 0);  chk("seq_out2", instr_out, 9'h012);
    tick(0, 9'd4, 0, 0);
    tick(0, 9'd5, 1, 0);
    tick(0, 9'd20, 0, 0); chk("squash_vld", instr_valid, 0);
    tick(0, 9'd21, 0, 0); chk("redir_out", instr_out, 9'h024); chk("redir_icount", instr_count, 5);
    tick(0, 9'h23, 0, 0);
    tick(0, 9'h24, 0, 1); chk("stall_out0", instr_out, 9'h033); chk("stall_ic0", instr_count, 7);
    chk("stall_cc0", cycle_count, 9);
    tick(0, 9'h30, 0, 1); chk("stall_out1", instr_out, 9'h033);
    tick(0, 9'h31, 1, 1); chk("stall_out2", instr_out, 9'h033); chk("stall_vld2", instr_valid, 1);
    tick(0, 9'h31, 0, 0); chk("stall_ic3", instr_count, 7); chk("stall_cc3", cycle_count, 12);
    tick(0, 9'h32, 0, 0); chk("stall_ic4", instr_count, 8); chk("post_stall_out", instr_out, 9'h041);

    // Halt on the fourth fetch
    mem[9'h100] = 9'h0A0; mem[9'h101] = 9'h0A1; mem[9'h102] = 9'h0A2; mem[9'h103] = HALT;
    obs_dones = 0;
    tick(1, 9'h100, 0, 0);
    tick(0, 9'h100, 0, 0);
    tick(0, 9'h101, 0, 0);
    tick(0, 9'h102, 0, 0);
    tick(0, 9'h103, 0, 0);
    tick(0, 9'h104, 0, 0); chk("halt_done", done, 1); chk("halt_out", instr_out, HALT);
    tick(0, 9'h105, 1, 1); chk("halt_ic", instr_count, 4); chk("halt_busy", busy, 0);
    chk("halt_vld", instr_valid, 0); chk("halt_cc", cycle_count, 5);
    tick(0, 9'h106, 0, 1);
    tick(0, 9'h107, 0, 0); chk("frozen_ic", instr_count, 4); chk("frozen_cc", cycle_count, 5);
    chk("done_pulses", obs_dones, 1);

    // Saturation of the narrow counters
    tick(1, 9'h40, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 9'(9'h41 + i), 0, 0);
    tick(0, 9'h60, 0, 0);
    chk("sat_cc4", cycle_count4, 15); chk("sat_ic4", instr_count4, 15);
    chk("wide_cc", cycle_count, 20); chk("wide_ic", instr_count, 19);

    // Asynchronous reset mid-run
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_vld", instr_valid, 0); chk("async_busy", busy, 0); chk("async_out", instr_out, 0);
    chk("async_ic", instr_count, 0); chk("async_cc", cycle_count, 0); chk("async_done", done, 0);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 512; a++)
      mem[a] = ($urandom_range(0, 29) == 0) ? HALT : 9'($urandom_range(0, 510));
    tick(0, 9'h10, 1, 1); chk("idle_busy0", busy, 0);
    tick(0, 9'h11, 0, 0); chk("idle_busy1", busy, 0);
    tick(1, 9'h12, 0, 0);
    tick(0, 9'h13, 0, 0); chk("restart_ic", instr_count, 0); chk("restart_cc", cycle_count, 0);
    chk("restart_busy", busy, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit s;
      s = (m_state == M_RUN) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0);
      tick(s, 9'($urandom_range(0, 511)), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter instr_width, default 9: width of instruction address and instruction word.
REQ-002 Parameter count_width, default 16: width of the performance counters.
REQ-003 Parameter halt_instr, default 9'h1FF: encoding that terminates the program.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 start  in  1  begin or restart fetching; same cycle as the program counter's start.
REQ-007 pc_in  in  instr_width  current PC from the program counter.
REQ-008 redirect  in  1  branch taken this cycle (branch && taken at the program counter).
REQ-009 stall  in  1  downstream cannot accept instr_out this cycle.
REQ-010 mem_addr  out  instr_width  instruction memory address.
REQ-011 mem_rdata  in  instr_width  instruction memory data, valid one cycle after mem_addr.
REQ-012 instr_out  out  instr_width  fetched instruction.
REQ-013 instr_valid  out  1  instr_out holds a valid, unsquashed instruction.
REQ-014 busy  out  1  high in RUN.
REQ-015 done  out  1  one-cycle pulse when halt is consumed.
REQ-016 instr_count  out  count_width  instructions consumed since last start.
REQ-017 cycle_count  out  count_width  RUN cycles since last start.

Function
REQ-018 FSM states: IDLE, RUN, DONE; busy = (state == RUN).
REQ-019 IDLE: instr_valid 0, no requests issued; start -> RUN.
REQ-020 start in any state: next state RUN, counters cleared to 0, pending request and hold register invalidated; first request issued in the following cycle.
REQ-021 mem_addr = pc_in combinationally in every state.
REQ-022 A request is issued in a RUN cycle with stall == 0 or instr_valid == 0.
REQ-023 A request issued in cycle N yields instr_valid = 1 and instr_out = mem_rdata in cycle N+1, unless squashed.
REQ-024 redirect high in cycle N squashes the request of cycle N: instr_valid = 0 in cycle N+1.
REQ-025 stall high while instr_valid = 1: instr_out and instr_valid held unchanged (hold register captures mem_rdata), no new request issued.
REQ-026 Accept = instr_valid && !stall; each accept increments instr_count by 1.
REQ-027 Accept of instr_out == halt_instr: done = 1 that cycle, next state DONE; in-flight request discarded.
REQ-028 DONE: instr_valid 0, done 0, counters frozen; start -> RUN.
REQ-029 cycle_count increments by 1 every RUN cycle, including stalled ones.
REQ-030 Both counters saturate at 2^count_width - 1; no wrap-around.
REQ-031 redirect and stall in the same cycle: stall holds the current instruction; the squash of REQ-024 still applies to any request issued in that cycle.
REQ-032 redirect, stall and mem_rdata are ignored outside RUN.

Reset
REQ-033 While reset = 1: state IDLE, instr_valid 0, done 0, busy 0, instr_out 0, counters 0, hold register invalid.
REQ-034 Reset asserted mid-RUN takes effect without waiting for clk; after release the block stays in IDLE until start.

Verification
REQ-035 Reset, start with pc_in 0,1,2, mem_rdata = address+9'h010 -> instr_valid from cycle 2, instr_out 9'h010, 9'h011, 9'h012; busy 1.
REQ-036 redirect at pc_in 5, next pc_in 20 -> the instruction for address 5 is never valid; the next valid instr_out is mem[20]; instr_count skips it.
REQ-037 stall for 3 cycles while instr_out = 9'h033 and mem_rdata changing -> instr_out stays 9'h033 and instr_valid 1; instr_count +1 only after release; cycle_count +3.
REQ-038 Memory returns 9'h1FF at the 4th fetch -> done pulses once, instr_count = 4, state DONE, instr_valid 0, counters frozen.
REQ-039 Preload cycle_count near max with count_width 4 and run 20 cycles -> cycle_count stops at 15.
REQ-040 Assert reset between clock edges mid-RUN -> outputs reach reset values before the next edge; start restarts with counters at 0.
